updown_counter_mod: RTL

Parametrised up/down counter with synchronous load, count enable and a runtime-programmable modulus.
- Selectable wrap or saturate behaviour at the boundaries.
- Registered terminal-count pulse.
- Sticky overflow and underflow flags.
- Drop-in successor to the fixed 8-bit up/down/load counter; used as a general event, timer and address counter.

---
 rtl/updown_counter_pkg.sv | 15 +
 rtl/updown_counter_presc.sv | 43 ++++
 rtl/updown_counter_mod.sv | 108 ++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the up/down counter slice.
package updown_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_PRE_W = 4;

endpackage

// File: rtl/updown_counter_presc.sv
// Prescaler: counts enabled cycles and strobes a step when the count reaches presc_i.
module updown_counter_presc
  import updown_counter_pkg::*;
#(
  parameter int PRE_W = DEFAULT_PRE_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] presc_i,
  output logic             step_o
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  // Next prescale count and step strobe
  always_comb begin
    cnt_d  = cnt_q;
    step_o = 1'b0;
    if (en_i) begin
      // >= so that lowering presc at runtime cannot strand the count above it
      if (cnt_q >= presc_i) begin
        step_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescale count register; cleared by reset and by a counter load
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with load, programmable modulus, wrap/saturate, tc pulse and sticky flags.
// Optional prescaler enabled by defining UPDOWN_COUNTER_MOD_PRESCALE_EN.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef UPDOWN_COUNTER_MOD_PRESCALE_EN
  , parameter int             PRE_W   = DEFAULT_PRE_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] cin,
  input  logic             clr_flags,
`ifdef UPDOWN_COUNTER_MOD_PRESCALE_EN
  input  logic [PRE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] cout_q, cout_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(sat);

`ifdef UPDOWN_COUNTER_MOD_PRESCALE_EN
  updown_counter_presc #(
    .PRE_W (PRE_W)
  ) u_presc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (load),
    .en_i    (en),
    .presc_i (presc),
    .step_o  (step_s)
  );
`else
  assign step_s = en;
`endif

  // Next count, terminal-count pulse and flags
  always_comb begin
    cout_d = cout_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q & ~clr_flags;
    unf_d  = unf_q & ~clr_flags;
    if (load) begin
      cout_d = (cin > max_val) ? max_val : cin;
    end else if (step_s) begin
      if (up == DIR_UP) begin
        if (cout_q < max_val) begin
          cout_d = cout_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cout_d = (mode_s == MODE_SAT) ? max_val : '0;
          tc_d   = 1'b1;
          ovf_d  = 1'b1;
        end
      end else begin
        // A modulus lowered below the count pulls the count down without a boundary event
        if (cout_q > max_val) begin
          cout_d = max_val;
        end else if (cout_q != '0) begin
          cout_d = cout_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cout_d = (mode_s == MODE_SAT) ? '0 : max_val;
          tc_d   = 1'b1;
          unf_d  = 1'b1;
        end
      end
    end else begin
      cout_d = cout_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= RST_VAL;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign cout = cout_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule
